// File: rtl/rps_pkg.sv
// rps_pkg: choice/strategy codes, round FSM states and the round judging rule
package rps_pkg;
  typedef enum logic [1:0] {ROCK = 2'b00, SCISSOR = 2'b01, PAPER = 2'b10, INVALID = 2'b11} choice_e;
  typedef enum logic [1:0] {STRAT_RANDOM = 2'b00, STRAT_MARKOV = 2'b01, STRAT_REINFORCE = 2'b10} strat_e;
  typedef enum logic [2:0] {IDLE, CAPTURE, JUDGE, UPDATE, DRAW_U, DRAW_C} state_e;
  function automatic logic [2:0] judge(input logic [1:0] user, input logic [1:0] com);
    logic [1:0] c;
    logic beats;
    c = (com == INVALID) ? ROCK : com;
    beats = (user == ROCK && c == SCISSOR) || (user == SCISSOR && c == PAPER) || (user == PAPER && c == ROCK);
    judge = (user == c) ? 3'b001 : beats ? 3'b100 : 3'b010;
  endfunction
endpackage

// File: rtl/key_edge_sync.sv
// key_edge_sync: synchronizes an active-low key and pulses one cycle on its press edge
module key_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic press
);
  // top bit holds the previous synchronized level for edge detection
  logic [SYNC_STAGES:0] sync;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) sync <= '1;
    else sync <= {sync[SYNC_STAGES-1:0], key_n};
  assign press = sync[SYNC_STAGES] & ~sync[SYNC_STAGES-1];
endmodule

// File: rtl/rps_round_controller.sv
// rps_round_controller: sequences one rock-paper-scissors round per start key press
module rps_round_controller
  import rps_pkg::*;
#(
  parameter int SCORE_W      = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int DRAW_TIMEOUT = 20000
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start_n,
  input  logic [1:0]         user_choice,
  input  logic [1:0]         strategy_sel,
  input  logic [1:0]         com_ra,
  input  logic [1:0]         com_m,
  input  logic [1:0]         com_re,
  output logic [1:0]         user_loaded,
  output logic [1:0]         com_loaded,
  output logic [SCORE_W-1:0] user_score,
  output logic [SCORE_W-1:0] com_score,
  output logic               uwin,
  output logic               cwin,
  output logic               equ,
  output logic               err_invalid,
  output logic               strat_update,
  output logic [3:0]         strat_comb,
  output logic [1:0]         strat_reward,
  output logic               draw_req,
  output logic               draw_sel,
  output logic [1:0]         draw_choice,
  input  logic               draw_done,
  output logic               busy
);
  localparam int CW = $clog2(DRAW_TIMEOUT + 1);
  state_e state, state_next;
  logic press, in_draw, draw_end;
  logic [CW-1:0] cnt;
  logic [1:0] com_mux;
  logic [2:0] res;
  key_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .key_n(start_n),
    .press(press)
  );
  assign com_mux = (strategy_sel == STRAT_MARKOV) ? com_m : (strategy_sel == STRAT_REINFORCE) ? com_re : com_ra;
  assign res = judge(user_loaded, com_loaded);
  assign in_draw = state == DRAW_U || state == DRAW_C;
  assign draw_end = draw_done || cnt == CW'(DRAW_TIMEOUT - 1);
  assign strat_comb = {com_loaded, user_loaded};
  assign strat_reward = cwin ? 2'b01 : uwin ? 2'b11 : 2'b00;
  always_comb begin
    state_next = state;
    busy = state != IDLE;
    draw_req = in_draw;
    draw_sel = state == DRAW_C;
    draw_choice = (state == DRAW_U) ? user_loaded : (state == DRAW_C) ? com_loaded : 2'b00;
    case (state)
      IDLE:    state_next = press ? CAPTURE : IDLE;
      CAPTURE: state_next = JUDGE;
      JUDGE:   state_next = (user_loaded == INVALID) ? IDLE : UPDATE;
      UPDATE:  state_next = DRAW_U;
      DRAW_U:  state_next = draw_end ? DRAW_C : DRAW_U;
      DRAW_C:  state_next = draw_end ? IDLE : DRAW_C;
      default: state_next = IDLE;
    endcase
  end
  // the timeout count restarts whenever a draw state is (re)entered
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      strat_update <= 1'b0;
    end else begin
      state <= state_next;
      cnt <= (in_draw && state_next == state) ? cnt + 1'b1 : '0;
      strat_update <= state == UPDATE;
    end
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      user_loaded <= '0;
      com_loaded <= '0;
      user_score <= '0;
      com_score <= '0;
      {uwin, cwin, equ, err_invalid} <= '0;
    end else if (state == CAPTURE) begin
      user_loaded <= user_choice;
      com_loaded <= com_mux;
      {uwin, cwin, equ, err_invalid} <= '0;
    end else if (state == JUDGE) begin
      if (user_loaded == INVALID) err_invalid <= 1'b1;
      else begin
        {uwin, cwin, equ} <= res;
        user_score <= user_score + SCORE_W'(res[2] && user_score != '1);
        com_score <= com_score + SCORE_W'(res[1] && com_score != '1);
      end
    end
endmodule

// File: tb/tb_rps_round_controller.sv
// tb_rps_round_controller: randomized rounds checked against an arithmetic game model
module tb_rps_round_controller;
  localparam int SS = 2;
  localparam int DT = 20000;
  logic CLOCK_50 = 1'b0, reset = 1'b1, start_n = 1'b1, draw_done = 1'b0;
  logic [1:0] user_choice = '0, strategy_sel = '0, com_ra = '0, com_m = '0, com_re = '0;
  logic [1:0] user_loaded, com_loaded, strat_reward, draw_choice;
  logic [7:0] user_score, com_score;
  logic uwin, cwin, equ, err_invalid, strat_update, draw_req, draw_sel, busy;
  logic [3:0] strat_comb;
  int n_checks = 0, n_fail = 0;
  int exp_us = 0, exp_cs = 0;
  rps_round_controller #(.SCORE_W(8), .SYNC_STAGES(SS), .DRAW_TIMEOUT(DT)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start_n(start_n), .user_choice(user_choice),
    .strategy_sel(strategy_sel), .com_ra(com_ra), .com_m(com_m), .com_re(com_re),
    .user_loaded(user_loaded), .com_loaded(com_loaded), .user_score(user_score),
    .com_score(com_score), .uwin(uwin), .cwin(cwin), .equ(equ), .err_invalid(err_invalid),
    .strat_update(strat_update), .strat_comb(strat_comb), .strat_reward(strat_reward),
    .draw_req(draw_req), .draw_sel(draw_sel), .draw_choice(draw_choice),
    .draw_done(draw_done), .busy(busy)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, "_scores"}, {user_score, com_score}, 0);
    check({tag, "_flags"}, {uwin, cwin, equ, err_invalid}, 0);
    check({tag, "_strat"}, {strat_update, strat_comb, strat_reward}, 0);
    check({tag, "_draw"}, {draw_req, draw_sel, draw_choice}, 0);
    check({tag, "_loaded_busy"}, {user_loaded, com_loaded, busy}, 0);
  endtask
  // one press-to-idle round; dly = cycles the drawer takes per panel
  task automatic round(input logic [1:0] u, input logic [1:0] sel, input logic [1:0] ra,
                       input logic [1:0] m, input logic [1:0] re, input int dly,
                       input bit extra, input bit lat);
    logic [1:0] c;
    int ce, d, nend, nupd, fupd, fsc, n0, n1, badc, dexp;
    bit order_bad, done, requeue;
    user_choice = u; strategy_sel = sel; com_ra = ra; com_m = m; com_re = re;
    c = (sel == 2'd1) ? m : (sel == 2'd2) ? re : ra;
    ce = (c == 2'd3) ? 0 : int'(c);
    nupd = 0; fupd = -1; fsc = -1; n0 = 0; n1 = 0; badc = 0; nend = 0;
    order_bad = 0; done = 0; requeue = 0;
    @(negedge CLOCK_50);
    start_n = 1'b0;
    for (int n = 1; n <= 60000 && !done; n++) begin
      @(negedge CLOCK_50);
      if (n == 3) start_n = 1'b1;
      if (strat_update) begin nupd++; if (fupd < 0) fupd = n; end
      if (fsc < 0 && (int'(user_score) != exp_us || int'(com_score) != exp_cs)) fsc = n;
      if (draw_req) begin
        if (draw_sel) n1++;
        else begin n0++; if (n1 > 0) order_bad = 1; end
        if (draw_choice != (draw_sel ? c : u)) badc++;
      end
      draw_done = draw_req && ((draw_sel ? n1 : n0) >= dly);
      if (extra && draw_req && !draw_sel && n0 == 1) start_n = 1'b0;
      if (extra && n0 == 4) start_n = 1'b1;
      if (n >= 3 && !busy) begin done = 1; nend = n; end
    end
    draw_done = 1'b0;
    start_n = 1'b1;
    check("round_finished", done, 1);
    repeat (6) begin
      @(negedge CLOCK_50);
      if (busy) requeue = 1;
    end
    check("no_requeued_round", requeue, 0);
    if (u == 2'd3) begin
      check("err_invalid", err_invalid, 1);
      check("invalid_flags", {uwin, cwin, equ}, 0);
      check("invalid_update", nupd, 0);
      check("invalid_draw", n0 + n1, 0);
      check("invalid_idle_cycle", nend, SS + 3);
    end else begin
      d = (ce - int'(u) + 3) % 3;
      if (d == 1 && exp_us < 255) exp_us++;
      if (d == 2 && exp_cs < 255) exp_cs++;
      dexp = (dly < DT) ? dly : DT;
      check("flags", {uwin, cwin, equ}, (d == 0) ? 1 : (d == 1) ? 4 : 2);
      check("err_clear", err_invalid, 0);
      check("reward", strat_reward, (d == 2) ? 1 : (d == 1) ? 3 : 0);
      check("strat_comb", strat_comb, {c, u});
      check("update_pulses", nupd, 1);
      check("update_latency", fupd, SS + 4);
      check("draw_user_cycles", n0, dexp);
      check("draw_com_cycles", n1, dexp);
      check("draw_order", order_bad, 0);
      check("draw_choice", badc, 0);
      if (lat) check("score_latency", fsc, SS + 3);
    end
    check("user_score", user_score, exp_us);
    check("com_score", com_score, exp_cs);
    check("user_loaded", user_loaded, u);
    check("com_loaded", com_loaded, c);
  endtask
  initial begin
    bit seen;
    repeat (3) @(negedge CLOCK_50);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge CLOCK_50);
    check_all_zero("post_reset");
    round(2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2, 0, 1);
    round(2'd1, 2'd1, 2'd2, 2'd0, 2'd2, 3, 0, 1);
    round(2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 1, 0, 0);
    round(2'd3, 2'd0, 2'd1, 2'd1, 2'd1, 1, 0, 0);
    round(2'd1, 2'd0, 2'd3, 2'd0, 2'd0, 2, 0, 1);
    round(2'd2, 2'd3, 2'd0, 2'd1, 2'd1, 10, 1, 1);
    for (int i = 0; i < 30; i++)
      round(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(1, 6), 0, 0);
    round(2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 100000, 0, 0);
    while (exp_us < 255) round(2'd0, 2'd0, 2'd1, 2'($urandom_range(0, 3)), 2'd0, 1, 0, 0);
    round(2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 1, 0, 0);
    check("saturated_uwin", uwin, 1);
    user_choice = 2'd2; strategy_sel = 2'd0; com_ra = 2'd0;
    @(negedge CLOCK_50);
    start_n = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    start_n = 1'b1;
    for (int i = 0; i < 100 && !(draw_req && draw_sel); i++) begin
      @(negedge CLOCK_50);
      draw_done = draw_req && !draw_sel;
    end
    draw_done = 1'b0;
    check("reached_draw_c", draw_req && draw_sel, 1);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge CLOCK_50);
    reset = 1'b0;
    exp_us = 0; exp_cs = 0;
    @(posedge CLOCK_50);
    #2 start_n = 1'b0;
    #3 start_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge CLOCK_50);
      if (busy) seen = 1;
    end
    check("glitch_no_round", seen, 0);
    check("glitch_scores", {user_score, com_score}, 0);
    round(2'd1, 2'd2, 2'd0, 2'd0, 2'd2, 2, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
